// File: rtl/adc_reader.sv
// Serial ADC reader: frames a 16-bit read with cs_n/sclk, sampling adc_sdata on each sclk rise.
// adc_valid pulses 33*SCLK_HALF cycles after cs_n falls; adc_start is ignored while busy (no queueing).
module adc_reader #(
  parameter int SCLK_HALF = 2,
  parameter int QUIET_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_start,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] adc_data,
  output logic        adc_valid,
  output logic        adc_busy,
  output logic        lead_err
);

  typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

  localparam logic [15:0] DIV_LAST   = 16'(SCLK_HALF - 1);
  localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  edge_q, edge_d;
  logic [15:0] shift_q, shift_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic [11:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        lead_q, lead_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      lead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lead_q  <= lead_d;
    end
  end

  // cnt_q is the sclk half-period divider in CONV and the quiet-time counter in QUIET.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    data_d  = data_q;
    valid_d = 1'b0;
    lead_d  = lead_q;
    case (state_q)
      IDLE: begin
        if (adc_start) begin
          state_d = CONV;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          cnt_d   = '0;
          edge_d  = '0;
          shift_d = '0;
        end
      end
      CONV: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          edge_d = edge_q + 6'd1;
          // Edges 1..32 toggle sclk; the 33rd closes the frame.
          if (edge_q == 6'd32) begin
            state_d = QUIET;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
            data_d  = shift_q[11:0];
            lead_d  = |shift_q[15:12];
            valid_d = 1'b1;
          end else begin
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              shift_d = {shift_q[14:0], adc_sdata};
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc_data  = data_q;
  assign adc_valid = valid_q;
  assign adc_busy  = (state_q != IDLE);
  assign lead_err  = lead_q;

endmodule
